// File: rtl/inst_fetch.sv
// RV32 instruction fetch stage: owns the PC, issues word reads and holds one
// fetched instruction for decode, dropping wrong-path data after redirects.
module inst_fetch #(
    parameter int unsigned    XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_data,
    input  logic            mem_resp_err,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_inst,
    output logic [1:0]      out_fault
);

    localparam logic [XLEN-1:0] NOP_INST  = XLEN'(32'h0000_0013);
    localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);
    localparam logic [1:0]      FAULT_NONE = 2'b00;
    localparam logic [1:0]      FAULT_MIS  = 2'b10;

    typedef enum logic [1:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t          state, state_n;
    logic [XLEN-1:0] pc, pc_n;
    logic            drop, drop_n;
    logic [XLEN-1:0] out_pc_n, out_inst_n;
    logic [1:0]      out_fault_n;
    logic            misaligned_c;
    logic            accepted_c;

    assign mem_req_addr = pc;
    assign misaligned_c = (redirect_pc[1:0] != 2'b00);
    assign accepted_c   = mem_req_valid & mem_req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_BOOT;
            pc            <= RESET_PC;
            drop          <= 1'b0;
            mem_req_valid <= 1'b0;
            out_valid     <= 1'b0;
            out_pc        <= '0;
            out_inst      <= '0;
            out_fault     <= FAULT_NONE;
        end else begin
            state         <= state_n;
            pc            <= pc_n;
            drop          <= drop_n;
            mem_req_valid <= (state_n == S_REQ);
            out_valid     <= (state_n == S_HOLD);
            out_pc        <= out_pc_n;
            out_inst      <= out_inst_n;
            out_fault     <= out_fault_n;
        end
    end

    // Redirects win over every other event except in BOOT; a misaligned target
    // never reaches memory and is reported through the output buffer instead.
    always_comb begin
        state_n     = state;
        pc_n        = pc;
        drop_n      = drop;
        out_pc_n    = out_pc;
        out_inst_n  = out_inst;
        out_fault_n = out_fault;

        if (state != S_BOOT && redirect_valid) begin
            pc_n = redirect_pc;
            if (misaligned_c) begin
                state_n     = S_HOLD;
                drop_n      = 1'b0;
                out_pc_n    = redirect_pc;
                out_inst_n  = NOP_INST;
                out_fault_n = FAULT_MIS;
            end else begin
                case (state)
                    S_REQ: begin
                        if (accepted_c) begin
                            state_n = S_WAIT;
                            drop_n  = 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (mem_resp_valid) begin
                            state_n = S_REQ;
                            drop_n  = 1'b0;
                        end else begin
                            drop_n = 1'b1;
                        end
                    end
                    S_HOLD:  state_n = S_REQ;
                    default: state_n = state;
                endcase
            end
        end else begin
            case (state)
                S_BOOT: state_n = S_REQ;
                S_REQ: begin
                    if (accepted_c) state_n = S_WAIT;
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        if (drop) begin
                            drop_n  = 1'b0;
                            state_n = S_REQ;
                        end else begin
                            out_pc_n    = pc;
                            out_inst_n  = mem_resp_data;
                            out_fault_n = {1'b0, mem_resp_err};
                            state_n     = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (out_valid && out_ready) begin
                        pc_n    = pc + PC_STEP;
                        state_n = S_REQ;
                    end
                end
                default: state_n = S_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: table of sequential fetches plus directed redirect,
// fault, wrap and reset sequences, checked through request/output scoreboards.
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
        logic [1:0]  fault;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [1:0]  fault;
    } out_t;

    logic        clk;
    logic        rst_n;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        mem_resp_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [1:0]  out_fault;

    inst_fetch #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .mem_resp_err   (mem_resp_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_fault      (out_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          applied;
    int          miscompares;
    int          cycle;
    int          resp_delay;
    bit          ready_en;
    bit          pend;
    int          pcnt;
    logic [31:0] paddr;
    logic [31:0] mem [logic [31:0]];
    bit          err_at [logic [31:0]];
    logic [31:0] exp_addr [$];
    out_t        exp_out [$];
    int          hs_cyc [$];
    vec_t        vecs [5];

    function automatic logic [31:0] word(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0F0F);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic push_fetch(input logic [31:0] a);
        out_t e;
        e.pc    = a;
        e.inst  = word(a);
        e.fault = {1'b0, err_at.exists(a)};
        exp_addr.push_back(a);
        exp_out.push_back(e);
    endtask

    // One clock: score this cycle's handshakes, advance, then drive the memory side.
    task automatic step();
        logic        hs;
        logic        acc;
        logic [31:0] a;
        out_t        e;
        mem_req_ready = ready_en && (exp_addr.size() != 0);
        #0;
        hs  = out_valid && out_ready;
        acc = mem_req_valid && mem_req_ready;
        a   = mem_req_addr;
        if (hs) begin
            hs_cyc.push_back(cycle);
            if (exp_out.size() == 0) begin
                applied++;
                miscompares++;
                $display("FAIL unexpected_out: got pc %h inst %h, want no transfer", out_pc, out_inst);
            end else begin
                e = exp_out.pop_front();
                chk("out_pc", out_pc, e.pc);
                chk("out_inst", out_inst, e.inst);
                chk("out_fault", 32'(out_fault), 32'(e.fault));
            end
        end
        if (acc) chk("req_addr", a, exp_addr.pop_front());
        @(posedge clk);
        #1;
        cycle++;
        redirect_valid = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_err   = 1'b0;
        mem_resp_data  = '0;
        if (acc) begin
            pend  = 1'b1;
            pcnt  = resp_delay;
            paddr = a;
        end
        if (pend) begin
            pcnt--;
            if (pcnt == 0) begin
                pend           = 1'b0;
                mem_resp_valid = 1'b1;
                mem_resp_data  = word(paddr);
                mem_resp_err   = err_at.exists(paddr);
            end
        end
    endtask

    task automatic wait_out(input int budget);
        int n = 0;
        while (!out_valid && n < budget) begin
            step();
            n++;
        end
        chk("wait_out_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_addr.size() != 0 || exp_out.size() != 0) && n < budget) begin
            step();
            n++;
        end
        chk("idle_timeout", 32'(exp_addr.size() + exp_out.size()), 32'd0);
        exp_addr.delete();
        exp_out.delete();
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
    endtask

    initial begin
        applied = 0; miscompares = 0; cycle = 0; resp_delay = 1;
        ready_en = 1'b1; pend = 1'b0; pcnt = 0; paddr = '0;
        rst_n = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        mem_resp_data = '0; mem_resp_err = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; out_ready = 1'b1;

        vecs[0] = '{32'h8000_0000, 32'h00A0_0093, 1'b0, 2'b00};
        vecs[1] = '{32'h8000_0004, 32'h0010_8113, 1'b0, 2'b00};
        vecs[2] = '{32'h8000_0008, 32'h0020_81B3, 1'b0, 2'b00};
        vecs[3] = '{32'h8000_000C, 32'h4020_8233, 1'b0, 2'b00};
        vecs[4] = '{32'h8000_0010, 32'hDEAD_BEEF, 1'b1, 2'b01};
        foreach (vecs[i]) begin
            mem[vecs[i].addr] = vecs[i].data;
            if (vecs[i].err) err_at[vecs[i].addr] = 1'b1;
        end

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_out_fault", 32'(out_fault), 32'd0);
        chk("rst_req_addr", mem_req_addr, RESET_PC);
        rst_n = 1'b1;

        // Sequential fetch table, including the access fault at 0x8000_0010
        for (int i = 0; i < 5; i++) begin
            out_t e;
            e.pc = vecs[i].addr; e.inst = vecs[i].data; e.fault = vecs[i].fault;
            exp_addr.push_back(vecs[i].addr);
            exp_out.push_back(e);
        end
        hs_cyc.delete();
        wait_idle(60);
        chk("hs_count", 32'(hs_cyc.size()), 32'd5);
        for (int i = 0; i + 1 < hs_cyc.size(); i++)
            chk("hs_interval", 32'(hs_cyc[i+1] - hs_cyc[i]), 32'd3);

        // Decode stall in HOLD for 5 cycles
        redirect(32'h8000_0000);
        out_ready = 1'b0;
        push_fetch(32'h8000_0000);
        wait_out(20);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_pc", out_pc, 32'h8000_0000);
            chk("stall_inst", out_inst, 32'h00A0_0093);
            chk("stall_no_req", 32'(mem_req_valid), 32'd0);
            step();
        end
        out_ready = 1'b1;
        wait_idle(20);

        // Redirect while WAIT for 0x8000_0004; its response must be dropped
        resp_delay = 3;
        exp_addr.push_back(32'h8000_0004);
        wait_idle(10);
        redirect(32'h8000_0100);
        resp_delay = 1;
        push_fetch(32'h8000_0100);
        for (int i = 0; i < 3; i++) begin
            chk("drop_no_out", 32'(out_valid), 32'd0);
            step();
        end
        wait_idle(20);

        // Redirect and handshake in the same HOLD cycle
        out_ready = 1'b0;
        push_fetch(32'h8000_0104);
        wait_out(20);
        out_ready = 1'b1;
        redirect(32'h8000_0200);
        chk("hs_with_redirect", 32'(exp_out.size()), 32'd0);
        push_fetch(32'h8000_0200);
        wait_idle(20);

        // Misaligned redirect target
        out_ready = 1'b0;
        redirect(32'h8000_0102);
        begin
            out_t e;
            e.pc = 32'h8000_0102; e.inst = 32'h0000_0013; e.fault = 2'b10;
            exp_out.push_back(e);
        end
        for (int i = 0; i < 2; i++) begin
            chk("mis_valid", 32'(out_valid), 32'd1);
            chk("mis_fault", 32'(out_fault), 32'd2);
            chk("mis_inst", out_inst, 32'h0000_0013);
            chk("mis_no_req", 32'(mem_req_valid), 32'd0);
            step();
        end
        push_fetch(32'h8000_0106);
        out_ready = 1'b1;
        wait_idle(20);

        // PC wrap-around
        redirect(32'hFFFF_FFFC);
        push_fetch(32'hFFFF_FFFC);
        push_fetch(32'h0000_0000);
        wait_idle(30);

        // Asynchronous reset in WAIT
        resp_delay = 4;
        exp_addr.push_back(32'h0000_0004);
        wait_idle(10);
        rst_n = 1'b0;
        #1;
        chk("arst_req_valid", 32'(mem_req_valid), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_pc", out_pc, 32'd0);
        chk("arst_out_inst", out_inst, 32'd0);
        chk("arst_out_fault", 32'(out_fault), 32'd0);
        chk("arst_req_addr", mem_req_addr, RESET_PC);
        pend = 1'b0;
        mem_resp_valid = 1'b0;
        resp_delay = 1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_fetch(RESET_PC);
        wait_idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
